// File: rtl/spc_cfg_tx.sv
// spc_cfg_tx: serialises a WIDTH-bit configuration word into a downstream spc2 register
// Ports: Clk/Resetn clock and async active-low reset; Start/Conf_in launch a transfer
// (accepted only when Ready); Abort cancels a running transfer; Done pulses on completion;
// Cfg_resetn/Cfg_clk/Cfg_in/Cfg_strobe drive the downstream register, all from flops.
module spc_cfg_tx #(
    parameter int WIDTH      = 16,
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [WIDTH-1:0] Conf_in,
    input  logic             Abort,
    output logic             Ready,
    output logic             Done,
    output logic             Cfg_resetn,
    output logic             Cfg_clk,
    output logic             Cfg_in,
    output logic             Cfg_strobe
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [6:0] RST_LAST = 7'(RST_CYCLES - 1);
    localparam logic [6:0] DIV_LAST = 7'(DIV - 1);
    localparam logic [6:0] HALF     = 7'(DIV / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RST, SHIFT, STROBE} state_t;

    state_t           state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic ready_q, ready_d, done_q, done_d, resetn_q, resetn_d;
    logic clk_q, clk_d, in_q, in_d, strobe_q, strobe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (Start) begin
                state_d = RST;
                cnt_d   = '0;
                idx_d   = '0;
                sh_d    = Conf_in;
            end
            RST: if (cnt_q == RST_LAST) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 7'd1;
            SHIFT: if (cnt_q == DIV_LAST) begin
                cnt_d = '0;
                // last bit stays in sh_q[0] so Cfg_in holds it through STROBE
                if (idx_q == IDX_LAST) state_d = STROBE;
                else begin
                    idx_d = idx_q + IW'(1);
                    sh_d  = sh_q >> 1;
                end
            end else cnt_d = cnt_q + 7'd1;
            STROBE: if (cnt_q == DIV_LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else cnt_d = cnt_q + 7'd1;
            default: state_d = IDLE;
        endcase
        if (Abort && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
        // outputs are decoded from next state so they register in step with it
        ready_d  = state_d == IDLE;
        resetn_d = state_d != RST;
        clk_d    = state_d == SHIFT && cnt_d >= HALF;
        in_d     = (state_d == SHIFT || state_d == STROBE) && sh_d[0];
        strobe_d = state_d == STROBE;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            resetn_q <= 1'b0;
            clk_q    <= 1'b0;
            in_q     <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            resetn_q <= resetn_d;
            clk_q    <= clk_d;
            in_q     <= in_d;
            strobe_q <= strobe_d;
        end
    end

    assign Ready      = ready_q;
    assign Done       = done_q;
    assign Cfg_resetn = resetn_q;
    assign Cfg_clk    = clk_q;
    assign Cfg_in     = in_q;
    assign Cfg_strobe = strobe_q;
endmodule

// File: tb/tb_spc_cfg_tx.sv
// tb_spc_cfg_tx: scoreboard bench for spc_cfg_tx (default and DIV=2 instances)
module tb_spc_cfg_tx;
    localparam int W = 16, D = 4, R = 2, LAT = R + (W + 1) * D;
    localparam logic [15:0] S561 = 16'b1000011010100000;
    localparam logic [15:0] S657 = 16'b1110101001100000;

    logic clk = 0, Resetn = 0, Start = 0, Abort = 0, Start2 = 0;
    logic [15:0] Conf_in = '0;
    logic [15:0] Conf_in2 = 16'h0001;
    logic Ready, Done, Cfg_resetn, Cfg_clk, Cfg_in, Cfg_strobe;
    logic Ready2, Done2, Cfg_resetn2, Cfg_clk2, Cfg_in2, Cfg_strobe2;
    logic zero = 0;
    int n_vec = 0, n_fail = 0, cyc = 0;
    bit exp_bits[$];
    int exp_done[$];

    spc_cfg_tx #(.WIDTH(W), .DIV(D), .RST_CYCLES(R)) dut (
        .Clk(clk), .Resetn(Resetn), .Start(Start), .Conf_in(Conf_in), .Abort(Abort),
        .Ready(Ready), .Done(Done), .Cfg_resetn(Cfg_resetn), .Cfg_clk(Cfg_clk),
        .Cfg_in(Cfg_in), .Cfg_strobe(Cfg_strobe));

    spc_cfg_tx #(.WIDTH(16), .DIV(2), .RST_CYCLES(1)) dut2 (
        .Clk(clk), .Resetn(Resetn), .Start(Start2), .Conf_in(Conf_in2), .Abort(zero),
        .Ready(Ready2), .Done(Done2), .Cfg_resetn(Cfg_resetn2), .Cfg_clk(Cfg_clk2),
        .Cfg_in(Cfg_in2), .Cfg_strobe(Cfg_strobe2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_seq(input logic [15:0] seq, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(seq[15-i]);
    endtask

    task automatic issue(input logic [15:0] w, input logic ab, input bit exp_d);
        @(negedge clk);
        chk("ready_before_start", Ready, 1);
        Start = 1; Conf_in = w; Abort = ab;
        @(posedge clk); #1;
        Start = 0; Abort = 0;
        chk("ready_after_accept", Ready, 0);
        if (exp_d) exp_done.push_back(cyc + LAT);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 300 && (exp_bits.size() != 0 || exp_done.size() != 0); i++) @(posedge clk);
        chk("drain", exp_bits.size() + exp_done.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    logic prev_clk = 0, prev_rdy = 0;
    int rrun = 0, srun = 0;
    always @(negedge clk) begin
        if (!Resetn) begin
            prev_clk = 0; prev_rdy = 0; rrun = 0; srun = 0;
        end else begin
            if (Cfg_clk && !prev_clk) begin
                if (exp_bits.size() == 0) chk("bit_extra", 1, 0);
                else chk("bit", Cfg_in, exp_bits.pop_front());
            end
            if (Done) begin
                if (exp_done.size() == 0) chk("done_extra", 1, 0);
                else chk("done_cycle", cyc, exp_done.pop_front());
            end
            if (!Cfg_resetn) begin
                if (rrun > 0 || prev_rdy) rrun++;
            end else if (rrun > 0) begin
                chk("cfg_resetn_low_len", rrun, R);
                rrun = 0;
            end
            if (Cfg_strobe) srun++;
            else if (srun > 0) begin
                chk("strobe_len", srun, D);
                srun = 0;
            end
            prev_clk = Cfg_clk;
            prev_rdy = Ready;
        end
    end

    initial begin
        #1;
        chk("reset_outputs", {Ready, Done, Cfg_resetn, Cfg_clk, Cfg_in, Cfg_strobe}, 0);
        chk("reset_outputs2", {Ready2, Done2, Cfg_resetn2, Cfg_clk2, Cfg_in2, Cfg_strobe2}, 0);
        repeat (2) @(posedge clk);
        #2 Resetn = 1;
        @(posedge clk); #1;
        chk("release_ready_resetn", {Ready, Cfg_resetn, Done}, 3'b110);

        // 0x561 then 0x657 started on the Done cycle
        push_seq(S561, 16);
        issue(16'h0561, 0, 1);
        push_seq(S657, 16);
        repeat (70) @(posedge clk);
        issue(16'h0657, 0, 1);
        wait_idle();

        // Start during SHIFT is ignored
        push_seq(S561, 16);
        issue(16'h0561, 0, 1);
        repeat (20) @(posedge clk);
        @(negedge clk); Start = 1; Conf_in = 16'hFFFF;
        @(posedge clk); #1 Start = 0;
        chk("ready_during_shift", Ready, 0);
        wait_idle();

        // Abort at bit 7, then Start+Abort together in IDLE
        push_seq(S561, 7);
        issue(16'h0561, 0, 0);
        repeat (30) @(posedge clk);
        @(negedge clk); Abort = 1;
        @(posedge clk); #1 Abort = 0;
        chk("abort_outputs", {Ready, Done, Cfg_resetn, Cfg_clk, Cfg_in, Cfg_strobe}, 6'b101000);
        chk("abort_bits_used", exp_bits.size(), 0);
        push_seq(S657, 16);
        issue(16'h0657, 1, 1);
        wait_idle();

        // Resetn pulsed at bit 3
        push_seq(S561, 3);
        issue(16'h0561, 0, 0);
        repeat (14) @(posedge clk);
        #2 Resetn = 0;
        #1 chk("midreset_outputs", {Ready, Done, Cfg_resetn, Cfg_clk, Cfg_in, Cfg_strobe}, 0);
        repeat (3) @(posedge clk);
        #2 Resetn = 1;
        @(posedge clk); #1;
        chk("midreset_release", {Ready, Cfg_resetn, Done}, 3'b110);
        wait_idle();

        // DIV=2, RST_CYCLES=1, word 0x0001
        @(negedge clk); Start2 = 1;
        @(posedge clk); #1 Start2 = 0;
        for (int k = 0; k <= 35; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            chk($sformatf("div2_cycle_%0d", k), {Cfg_resetn2, Cfg_clk2, Cfg_in2, Cfg_strobe2, Done2},
                {k != 0, k >= 1 && k <= 32 && (k - 1) % 2 == 1, k == 1 || k == 2,
                 k == 33 || k == 34, k == 35});
        end
        @(posedge clk); #1 chk("div2_ready", Ready2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
